// File: rtl/arp_ctrl.sv
// ARP sequencing controller: auto-answers incoming requests, resolves DES_IP with
// timed retries, and keeps a one-entry MAC cache for the resolved target.
module arp_ctrl #(
    parameter logic [31:0] DES_IP       = {8'd192, 8'd168, 8'd1, 8'd102},
    parameter logic [31:0] RETRY_CYCLES = 32'd125_000_000,
    parameter logic [3:0]  MAX_RETRY    = 4'd3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_start,
    input  logic        arp_rx_done,
    input  logic        arp_rx_type,
    input  logic [47:0] src_mac,
    input  logic [31:0] src_ip,
    input  logic        tx_done,
    output logic        arp_tx_en,
    output logic        arp_tx_type,
    output logic [47:0] des_mac,
    output logic [31:0] des_ip,
    output logic        busy,
    output logic        cache_valid,
    output logic [47:0] cache_mac,
    output logic        req_fail
);

    typedef enum logic {
        IDLE    = 1'b0,
        TX_WAIT = 1'b1
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic        send_reply;
    logic        send_request;

    logic        reply_pend_reg;
    logic [47:0] rp_mac_reg;
    logic [31:0] rp_ip_reg;
    logic        req_outstanding_reg;
    logic        req_due_reg;
    logic [3:0]  retry_cnt_reg;
    logic [31:0] timer_reg;

    logic        rx_request;
    logic        rx_match;
    logic        tx_finish;
    logic        timer_expire;

    assign rx_request   = arp_rx_done && !arp_rx_type;
    assign rx_match     = arp_rx_done && arp_rx_type && (src_ip == DES_IP);
    assign tx_finish    = (state_reg == TX_WAIT) && tx_done;
    assign timer_expire = req_outstanding_reg && (timer_reg == 32'd1);

    always_comb begin
        state_next   = state_reg;
        send_reply   = 1'b0;
        send_request = 1'b0;
        case (state_reg)
            IDLE: begin
                // Answering a peer always takes precedence over our own request.
                if (reply_pend_reg) begin
                    send_reply = 1'b1;
                    state_next = TX_WAIT;
                end else if (req_due_reg) begin
                    send_request = 1'b1;
                    state_next   = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (tx_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg           <= IDLE;
            arp_tx_en           <= 1'b0;
            arp_tx_type         <= 1'b0;
            des_mac             <= 48'd0;
            des_ip              <= 32'd0;
            busy                <= 1'b0;
            cache_valid         <= 1'b0;
            cache_mac           <= 48'd0;
            req_fail            <= 1'b0;
            reply_pend_reg      <= 1'b0;
            rp_mac_reg          <= 48'd0;
            rp_ip_reg           <= 32'd0;
            req_outstanding_reg <= 1'b0;
            req_due_reg         <= 1'b0;
            retry_cnt_reg       <= 4'd0;
            timer_reg           <= 32'd0;
        end else begin
            state_reg <= state_next;
            arp_tx_en <= send_reply || send_request;
            busy      <= (state_next == TX_WAIT);
            req_fail  <= 1'b0;

            if (send_reply) begin
                arp_tx_type <= 1'b1;
                des_mac     <= rp_mac_reg;
                des_ip      <= rp_ip_reg;
            end else if (send_request) begin
                arp_tx_type <= 1'b0;
                des_mac     <= 48'hff_ff_ff_ff_ff_ff;
                des_ip      <= DES_IP;
            end

            // A request arriving on the service edge re-arms the flag (newest wins).
            if (send_reply) begin
                reply_pend_reg <= 1'b0;
            end
            if (rx_request) begin
                reply_pend_reg <= 1'b1;
                rp_mac_reg     <= src_mac;
                rp_ip_reg      <= src_ip;
            end

            if (send_request) begin
                req_due_reg <= 1'b0;
            end
            if (req_outstanding_reg && (timer_reg != 32'd0)) begin
                timer_reg <= timer_reg - 32'd1;
            end
            if (tx_finish && !arp_tx_type && req_outstanding_reg) begin
                timer_reg <= RETRY_CYCLES;
            end
            if (timer_expire && !rx_match && !req_start) begin
                if (retry_cnt_reg < MAX_RETRY) begin
                    retry_cnt_reg <= retry_cnt_reg + 4'd1;
                    req_due_reg   <= 1'b1;
                end else begin
                    req_fail            <= 1'b1;
                    req_outstanding_reg <= 1'b0;
                end
            end

            // Later assignments override: a matching reply beats the timer,
            // and a fresh start beats everything.
            if (rx_match) begin
                cache_mac           <= src_mac;
                cache_valid         <= 1'b1;
                req_outstanding_reg <= 1'b0;
                req_due_reg         <= 1'b0;
                retry_cnt_reg       <= 4'd0;
                timer_reg           <= 32'd0;
            end
            if (req_start) begin
                req_outstanding_reg <= 1'b1;
                req_due_reg         <= 1'b1;
                retry_cnt_reg       <= 4'd0;
                timer_reg           <= 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_arp_ctrl.sv
// Randomized self-checking bench for arp_ctrl; expected transmission times and
// contents are derived from the protocol rules with plain cycle arithmetic.
module tb_arp_ctrl;

    localparam logic [31:0] DES_IP    = 32'hC0A8_0166;
    localparam int          RETRY     = 100;
    localparam int          MAX_RETRY = 2;
    localparam logic [47:0] BCAST     = 48'hff_ff_ff_ff_ff_ff;

    logic        clk;
    logic        rst_n;
    logic        req_start;
    logic        arp_rx_done;
    logic        arp_rx_type;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic        tx_done;
    logic        arp_tx_en;
    logic        arp_tx_type;
    logic [47:0] des_mac;
    logic [31:0] des_ip;
    logic        busy;
    logic        cache_valid;
    logic [47:0] cache_mac;
    logic        req_fail;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int tx_count = 0;
    int fail_count = 0;
    int exp_tx = 0;
    int exp_fail = 0;
    logic        exp_cache_valid = 1'b0;
    logic [47:0] exp_cache_mac = 48'd0;

    arp_ctrl #(
        .DES_IP(DES_IP),
        .RETRY_CYCLES(32'(RETRY)),
        .MAX_RETRY(4'(MAX_RETRY))
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_start(req_start),
        .arp_rx_done(arp_rx_done),
        .arp_rx_type(arp_rx_type),
        .src_mac(src_mac),
        .src_ip(src_ip),
        .tx_done(tx_done),
        .arp_tx_en(arp_tx_en),
        .arp_tx_type(arp_tx_type),
        .des_mac(des_mac),
        .des_ip(des_ip),
        .busy(busy),
        .cache_valid(cache_valid),
        .cache_mac(cache_mac),
        .req_fail(req_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (arp_tx_en) tx_count++;
        if (req_fail) fail_count++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] rand_mac();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[47:0];
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_en"}, 64'(arp_tx_en), 64'd0);
        check({tag, "_tx_type"}, 64'(arp_tx_type), 64'd0);
        check({tag, "_des_mac"}, 64'(des_mac), 64'd0);
        check({tag, "_des_ip"}, 64'(des_ip), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_cache_valid"}, 64'(cache_valid), 64'd0);
        check({tag, "_cache_mac"}, 64'(cache_mac), 64'd0);
        check({tag, "_req_fail"}, 64'(req_fail), 64'd0);
    endtask

    // One-cycle ARP reception (optionally with req_start); returns the sampling edge.
    task automatic pulse_rx(input logic typ, input logic [47:0] mac, input logic [31:0] ip,
                            input logic with_start, output int edge_n);
        @(posedge clk);
        #1;
        arp_rx_done = 1'b1;
        arp_rx_type = typ;
        src_mac     = mac;
        src_ip      = ip;
        req_start   = with_start;
        @(posedge clk);
        #1;
        edge_n      = cyc;
        arp_rx_done = 1'b0;
        req_start   = 1'b0;
        if (typ && ip == DES_IP) begin
            exp_cache_valid = 1'b1;
            exp_cache_mac   = mac;
        end
    endtask

    task automatic pulse_start(output int edge_n);
        @(posedge clk);
        #1;
        req_start = 1'b1;
        @(posedge clk);
        #1;
        edge_n    = cyc;
        req_start = 1'b0;
    endtask

    task automatic expect_tx(input string tag, input int exp_cyc, input logic exp_typ,
                             input logic [47:0] exp_mac, input logic [31:0] exp_ip);
        int   limit;
        logic found;
        int   seen;
        found = 1'b0;
        seen  = 0;
        limit = exp_cyc - cyc + 5;
        if (limit < 5) limit = 5;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge clk);
            if (arp_tx_en) begin
                found = 1'b1;
                seen  = cyc;
            end
        end
        exp_tx++;
        check({tag, "_found"}, 64'(found), 64'd1);
        if (found) begin
            $display("tx %s: cycle %0d type %0d des_mac %h des_ip %h", tag, seen, arp_tx_type, des_mac, des_ip);
            check({tag, "_cycle"}, 64'(seen), 64'(exp_cyc));
            check({tag, "_type"}, 64'(arp_tx_type), 64'(exp_typ));
            check({tag, "_des_mac"}, 64'(des_mac), 64'(exp_mac));
            check({tag, "_des_ip"}, 64'(des_ip), 64'(exp_ip));
            check({tag, "_busy"}, 64'(busy), 64'd1);
            @(negedge clk);
            check({tag, "_pulse"}, 64'(arp_tx_en), 64'd0);
            check({tag, "_hold_mac"}, 64'(des_mac), 64'(exp_mac));
        end
    endtask

    task automatic finish_tx(input string tag, input int delay, output int done_edge);
        repeat (delay) @(posedge clk);
        #1;
        check({tag, "_busy_before_done"}, 64'(busy), 64'd1);
        tx_done = 1'b1;
        @(posedge clk);
        #1;
        tx_done   = 1'b0;
        done_edge = cyc;
        @(negedge clk);
        check({tag, "_busy_after_done"}, 64'(busy), 64'd0);
    endtask

    task automatic check_quiet(input string tag, input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
        check({tag, "_tx_count"}, 64'(tx_count), 64'(exp_tx));
        check({tag, "_fail_count"}, 64'(fail_count), 64'(exp_fail));
        check({tag, "_cache_valid"}, 64'(cache_valid), 64'(exp_cache_valid));
        check({tag, "_cache_mac"}, 64'(cache_mac), 64'(exp_cache_mac));
    endtask

    initial begin
        int          e;
        int          d;
        int          exp_c;
        int          fc;
        logic        got_fail;
        logic [47:0] mac_a, mac_b, mac_c;
        logic [31:0] ip_a, ip_b, ip_c;

        rst_n       = 1'b0;
        req_start   = 1'b0;
        arp_rx_done = 1'b0;
        arp_rx_type = 1'b0;
        src_mac     = 48'd0;
        src_ip      = 32'd0;
        tx_done     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("post_reset");

        // Incoming requests with random senders; stray replies must be ignored.
        for (int k = 0; k < 6; k++) begin
            mac_a = (k == 0) ? 48'h11_22_33_44_55_66 : rand_mac();
            ip_a  = (k == 0) ? 32'hC0A8_0166 : 32'($urandom);
            pulse_rx(1'b0, mac_a, ip_a, 1'b0, e);
            expect_tx("reply", e + 1, 1'b1, mac_a, ip_a);
            if ($urandom_range(0, 1) == 1) begin
                pulse_rx(1'b1, rand_mac(), 32'h0A00_0000 | 32'($urandom_range(0, 255)), 1'b0, e);
            end
            finish_tx("reply", $urandom_range(1, 8), d);
        end
        check_quiet("replies", 20);

        // Resolution: one broadcast request, then a matching reply fills the cache.
        pulse_start(e);
        expect_tx("req", e + 1, 1'b0, BCAST, DES_IP);
        finish_tx("req", $urandom_range(1, 10), d);
        repeat ($urandom_range(5, 50)) @(posedge clk);
        pulse_rx(1'b1, 48'hAA_BB_CC_DD_EE_FF, DES_IP, 1'b0, e);
        @(negedge clk);
        check("resolve_cache_valid", 64'(cache_valid), 64'd1);
        check("resolve_cache_mac", 64'(cache_mac), 64'hAABBCCDDEEFF);
        check_quiet("resolved", 250);

        // No reply: first request plus MAX_RETRY retries, then req_fail.
        pulse_start(e);
        check("start_keeps_cache", 64'(cache_valid), 64'd1);
        exp_c = e + 1;
        for (int i = 0; i <= MAX_RETRY; i++) begin
            expect_tx("retry", exp_c, 1'b0, BCAST, DES_IP);
            finish_tx("retry", $urandom_range(1, 10), d);
            exp_c = d + RETRY + 1;
        end
        got_fail = 1'b0;
        fc = 0;
        for (int i = 0; i < RETRY + 20 && !got_fail; i++) begin
            @(negedge clk);
            if (req_fail) begin
                got_fail = 1'b1;
                fc = cyc;
            end
        end
        exp_fail++;
        check("fail_seen", 64'(got_fail), 64'd1);
        check("fail_cycle", 64'(fc), 64'(d + RETRY));
        @(negedge clk);
        check("fail_pulse", 64'(req_fail), 64'd0);
        $display("req_fail at cycle %0d", fc);
        check_quiet("failed", 300);

        // Priority: simultaneous request reception and req_start, plus newest-wins capture.
        mac_a = rand_mac();
        ip_a  = 32'($urandom);
        mac_b = rand_mac();
        ip_b  = 32'($urandom);
        mac_c = rand_mac();
        ip_c  = 32'($urandom);
        pulse_rx(1'b0, mac_a, ip_a, 1'b1, e);
        expect_tx("prio_reply", e + 1, 1'b1, mac_a, ip_a);
        pulse_rx(1'b0, mac_b, ip_b, 1'b0, e);
        pulse_rx(1'b0, mac_c, ip_c, 1'b0, e);
        finish_tx("prio_reply", $urandom_range(1, 6), d);
        expect_tx("prio_reply2", d + 1, 1'b1, mac_c, ip_c);
        finish_tx("prio_reply2", $urandom_range(1, 6), d);
        expect_tx("prio_req", d + 1, 1'b0, BCAST, DES_IP);
        finish_tx("prio_req", $urandom_range(1, 6), d);
        mac_a = rand_mac();
        pulse_rx(1'b1, mac_a, DES_IP, 1'b0, e);
        @(negedge clk);
        check("prio_cache_mac", 64'(cache_mac), 64'(mac_a));
        check_quiet("prio", 250);

        // A reply from another IP leaves the cache unchanged.
        pulse_rx(1'b1, rand_mac(), 32'hC0A8_0199, 1'b0, e);
        @(negedge clk);
        check("filter_cache_valid", 64'(cache_valid), 64'd1);
        check("filter_cache_mac", 64'(cache_mac), 64'(exp_cache_mac));

        // Reset during TX_WAIT with a reply and a request still pending.
        mac_b = rand_mac();
        ip_b  = 32'($urandom);
        pulse_rx(1'b0, mac_b, ip_b, 1'b0, e);
        expect_tx("rst_reply", e + 1, 1'b1, mac_b, ip_b);
        pulse_rx(1'b0, rand_mac(), 32'($urandom), 1'b0, e);
        pulse_start(e);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        exp_cache_valid = 1'b0;
        exp_cache_mac   = 48'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_quiet("after_reset", 300);
        check("after_reset_busy", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/arp_ctrl.md
Name: arp_ctrl

Overview:
- Sequencing controller for the ARP engine (arp_rx / arp_tx / crc32_d8 wrapper).
- Answers incoming ARP requests automatically and issues outgoing ARP requests for a fixed target IP, on a user start pulse or a retry timeout.
- Maintains a one-entry resolution cache for the target's MAC.
- Sits between user logic and the ARP wrapper's user interface, in the GMII clock domain. rx and tx clocks are tied to one clock.

Parameters:
- DES_IP, {8'd192,8'd168,8'd1,8'd102}, target IP to resolve; used as des_ip for requests.
- RETRY_CYCLES, 32'd125_000_000, wait after a request's tx_done before retrying (1 s at 125 MHz).
- MAX_RETRY, 4'd3, number of retries after the first request before declaring failure.

Ports:
- clk  input  1  GMII clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_start  input  1  single-cycle pulse: start resolving DES_IP.
- arp_rx_done  input  1  single-cycle pulse: ARP frame received for this board.
- arp_rx_type  input  1  received type, 0 = request, 1 = reply; valid with arp_rx_done.
- src_mac  input  48  sender MAC; valid with arp_rx_done.
- src_ip  input  32  sender IP; valid with arp_rx_done.
- tx_done  input  1  single-cycle pulse: frame transmission finished.
- arp_tx_en  output  1  single-cycle pulse: start ARP transmission.
- arp_tx_type  output  1  0 = request, 1 = reply.
- des_mac  output  48  destination MAC for the transmission.
- des_ip  output  32  destination IP for the transmission.
- busy  output  1  high from arp_tx_en until tx_done.
- cache_valid  output  1  cache_mac holds the MAC resolved for DES_IP.
- cache_mac  output  48  resolved MAC of DES_IP.
- req_fail  output  1  single-cycle pulse: resolution failed after retries.

Behaviour:
- Reset: all outputs 0 (arp_tx_en, arp_tx_type, des_mac, des_ip, busy, cache_valid, cache_mac, req_fail). All internal flags, counters and the timer are 0. The state is IDLE.
- Reset asserted mid-transmission aborts everything immediately. No pending work survives reset.
- Reply capture:
  - arp_rx_done with arp_rx_type=0 sets reply_pend and latches src_mac/src_ip into rp_mac/rp_ip.
  - A second request arriving before service overwrites rp_mac/rp_ip (newest wins). This is allowed in any state.
- Reply reception: arp_rx_done with arp_rx_type=1 and src_ip==DES_IP:
  - cache_mac <= src_mac, cache_valid <= 1 on the next edge.
  - Clears req_outstanding, req_due, retry_cnt and the timer.
  - Replies from any other IP are ignored.
- Request start:
  - req_start sets req_outstanding=1 and req_due=1, and clears retry_cnt and the timer.
  - A req_start while a request is outstanding restarts the sequence the same way.
  - cache_valid is not cleared by req_start.
- FSM, two states:
  - IDLE:
    - If reply_pend: issue a reply. arp_tx_en=1 for one cycle, arp_tx_type=1, des_mac=rp_mac, des_ip=rp_ip; clear reply_pend; go to TX_WAIT.
    - Else if req_due: issue a request. arp_tx_en=1, arp_tx_type=0, des_mac=48'hff_ff_ff_ff_ff_ff, des_ip=DES_IP; clear req_due; go to TX_WAIT.
    - Replies have priority over requests.
    - arp_tx_en is asserted on the edge after the condition is seen in IDLE (1-cycle latency).
  - TX_WAIT:
    - busy=1. arp_tx_type, des_mac and des_ip are held stable.
    - On tx_done: go to IDLE, busy=0. If the finished frame was a request and req_outstanding is still set, load timer=RETRY_CYCLES.
    - The earliest next arp_tx_en is 2 cycles after tx_done.
- Retry timer:
  - Decrements once per cycle while nonzero and req_outstanding=1.
  - When the timer reaches 1 (counting to expiry):
    - If retry_cnt<MAX_RETRY: retry_cnt++ and set req_due.
    - Else: pulse req_fail for one cycle and clear req_outstanding.
- Simultaneous events:
  - A request reception and req_start in the same cycle: both are latched; the reply goes first.
  - A matching reply on the same cycle as timer expiry: the reply wins; no retry and no req_fail.
  - tx_done while in IDLE is ignored.

Test Plan:
- Incoming request: arp_rx_done, type=0, src_mac=48'h11_22_33_44_55_66, src_ip=C0A8_0166. Required: arp_tx_en pulse 1 cycle later with arp_tx_type=1 and des_mac/des_ip equal to the latched values; busy stays high until tx_done.
- Request resolution (RETRY_CYCLES=100): req_start. Required: request with des_mac=FFFF_FFFF_FFFF, des_ip=DES_IP. After tx_done, a type=1 reply from C0A8_0166 with MAC AA_BB_CC_DD_EE_FF gives cache_valid=1, cache_mac=AABBCCDDEEFF, and no further arp_tx_en.
- Retry/fail (RETRY_CYCLES=100, MAX_RETRY=2, no reply): exactly 3 request pulses, each 100 cycles after the previous tx_done; req_fail pulses once 100 cycles after the third tx_done.
- Priority: req_start and an incoming request in the same cycle. Required: reply sent first, request sent after that reply's tx_done; two incoming requests during TX_WAIT produce one reply to the second sender.
- Filtering and mid-operation reset: a reply from C0A8_0199 leaves the cache unchanged; asserting rst_n=0 during TX_WAIT drives all outputs to 0, and no transmission follows after release.
